// File: rtl/weight_fetch_seq_if.sv
// Layer descriptor, ROM address/data and weight stream signals of the weight fetch sequencer.
// master = sequencer side, slave = controller / ROMs / MAC datapath side.
interface weight_fetch_seq_if #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 16,
    parameter int W_ADDR_WIDTH = 11,
    parameter int B_ADDR_WIDTH = 6,
    parameter int CH_WIDTH     = 5,
    parameter int K_WIDTH      = 2
);
    logic                    start;
    logic [W_ADDR_WIDTH-1:0] w_base;
    logic [B_ADDR_WIDTH-1:0] b_base;
    logic [CH_WIDTH-1:0]     out_ch;
    logic [CH_WIDTH-1:0]     in_ch;
    logic [K_WIDTH-1:0]      kernel;
    logic                    busy;
    logic                    done;
    logic [W_ADDR_WIDTH-1:0] w_addr;
    logic [WEIGHT_WIDTH-1:0] w_data;
    logic [B_ADDR_WIDTH-1:0] b_addr;
    logic [BIAS_WIDTH-1:0]   b_data;
    logic                    wt_valid;
    logic                    wt_ready;
    logic [WEIGHT_WIDTH-1:0] wt_data;
    logic [BIAS_WIDTH-1:0]   wt_bias;
    logic                    wt_first;
    logic                    wt_last;
    logic                    wt_layer_last;

    modport master (
        input  start, w_base, b_base, out_ch, in_ch, kernel, w_data, b_data, wt_ready,
        output busy, done, w_addr, b_addr, wt_valid, wt_data, wt_bias, wt_first, wt_last,
        wt_layer_last
    );

    modport slave (
        output start, w_base, b_base, out_ch, in_ch, kernel, w_data, b_data, wt_ready,
        input  busy, done, w_addr, b_addr, wt_valid, wt_data, wt_bias, wt_first, wt_last,
        wt_layer_last
    );
endinterface

// File: rtl/weight_fetch_seq.sv
// Walks a layer's weights in [out_ch][in_ch][kernel] order, reads weight/bias ROMs and
// streams (weight, bias, framing) beats through a 2-entry skid FIFO at 1 beat/cycle.
module weight_fetch_seq #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int BIAS_WIDTH   = 16,
    parameter int W_ADDR_WIDTH = 11,
    parameter int B_ADDR_WIDTH = 6,
    parameter int CH_WIDTH     = 5,
    parameter int K_WIDTH      = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    weight_fetch_seq_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic [WEIGHT_WIDTH-1:0] w;
        logic [BIAS_WIDTH-1:0]   b;
        logic                    first;
        logic                    last;
        logic                    layer_last;
    } beat_t;

    state_e                  state_q;
    logic                    busy_q, done_q;
    logic [W_ADDR_WIDTH-1:0] w_base_q, w_off_q;
    logic [B_ADDR_WIDTH-1:0] b_base_q;
    logic [CH_WIDTH-1:0]     out_ch_q, in_ch_q, oc_q, ic_q;
    logic [K_WIDTH-1:0]      kernel_q, k_q;
    logic                    pend_q, pend_first_q, pend_last_q, pend_ll_q;
    beat_t                   head_q, tail_q, beat_in;
    logic [1:0]              cnt_q;
    logic [2:0]              cnt_d;
    logic                    pop, issue, zero_size;
    logic                    k_end, ic_end, oc_end, is_first, is_last, is_ll;

    always_comb begin
        pop       = (cnt_q != 2'd0) && bus.wt_ready;
        // occupancy once this cycle's ROM return lands and the head pop retires
        cnt_d     = 3'(cnt_q) + 3'(pend_q) - 3'(pop);
        issue     = (state_q == S_FETCH) && (cnt_d < 3'd2);
        zero_size = (bus.out_ch == '0) || (bus.in_ch == '0) || (bus.kernel == '0);
        k_end     = (k_q  == kernel_q - K_WIDTH'(1));
        ic_end    = (ic_q == in_ch_q  - CH_WIDTH'(1));
        oc_end    = (oc_q == out_ch_q - CH_WIDTH'(1));
        is_first  = (ic_q == '0) && (k_q == '0);
        is_last   = ic_end && k_end;
        is_ll     = is_last && oc_end;
        beat_in   = '{w: bus.w_data, b: bus.b_data, first: pend_first_q,
                      last: pend_last_q, layer_last: pend_ll_q};
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.w_addr        = w_base_q + w_off_q;
    assign bus.b_addr        = b_base_q + B_ADDR_WIDTH'(oc_q);
    assign bus.wt_valid      = (cnt_q != 2'd0);
    assign bus.wt_data       = head_q.w;
    assign bus.wt_bias       = head_q.b;
    assign bus.wt_first      = head_q.first;
    assign bus.wt_last       = head_q.last;
    assign bus.wt_layer_last = head_q.layer_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            w_base_q     <= '0;
            w_off_q      <= '0;
            b_base_q     <= '0;
            out_ch_q     <= '0;
            in_ch_q      <= '0;
            kernel_q     <= '0;
            oc_q         <= '0;
            ic_q         <= '0;
            k_q          <= '0;
            pend_q       <= 1'b0;
            pend_first_q <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_ll_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pend_q <= issue;
            if (issue) begin
                pend_first_q <= is_first;
                pend_last_q  <= is_last;
                pend_ll_q    <= is_ll;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (zero_size) begin
                            // empty layer: no reads, addresses keep their old values
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_FETCH;
                            w_base_q <= bus.w_base;
                            b_base_q <= bus.b_base;
                            out_ch_q <= bus.out_ch;
                            in_ch_q  <= bus.in_ch;
                            kernel_q <= bus.kernel;
                            w_off_q  <= '0;
                            oc_q     <= '0;
                            ic_q     <= '0;
                            k_q      <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        // counters stop on the final read so the addresses hold afterwards
                        if (is_ll) begin
                            state_q <= S_DRAIN;
                        end else begin
                            w_off_q <= w_off_q + W_ADDR_WIDTH'(1);
                            if (k_end) begin
                                k_q <= '0;
                                if (ic_end) begin
                                    ic_q <= '0;
                                    oc_q <= oc_q + CH_WIDTH'(1);
                                end else begin
                                    ic_q <= ic_q + CH_WIDTH'(1);
                                end
                            end else begin
                                k_q <= k_q + K_WIDTH'(1);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_d == 3'd0 && !pend_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Shift-style FIFO: the head entry is always the register that drives wt_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d[1:0];
            case ({pend_q, pop})
                2'b01: head_q <= tail_q;
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= beat_in;
                    else               tail_q <= beat_in;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= beat_in;
                    end else begin
                        head_q <= beat_in;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_fetch_seq.sv
// Directed + randomized bench for weight_fetch_seq with behavioural ROMs and a
// queue-based reference of the expected beat stream and address walk.
module tb_weight_fetch_seq;
    localparam int WW = 8, BW = 16, WA = 11, BA = 6, CW = 5, KW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    weight_fetch_seq_if #(.WEIGHT_WIDTH(WW), .BIAS_WIDTH(BW), .W_ADDR_WIDTH(WA),
                          .B_ADDR_WIDTH(BA), .CH_WIDTH(CW), .K_WIDTH(KW)) bus ();

    weight_fetch_seq #(.WEIGHT_WIDTH(WW), .BIAS_WIDTH(BW), .W_ADDR_WIDTH(WA),
                       .B_ADDR_WIDTH(BA), .CH_WIDTH(CW), .K_WIDTH(KW))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    logic [WW-1:0] wrom [2**WA];
    logic [BW-1:0] brom [2**BA];

    // synchronous ROMs: address in cycle c, data in c+1
    always @(posedge clk) begin
        bus.w_data <= wrom[bus.w_addr];
        bus.b_data <= brom[bus.b_addr];
    end

    typedef struct {
        logic [WW-1:0] w;
        logic [BW-1:0] b;
        logic          f, l, ll;
    } exp_t;

    exp_t exp_q[$];
    int   exp_addr[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    bit   pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},   32'(bus.busy), 0);
        check({tag, "_done"},   32'(bus.done), 0);
        check({tag, "_valid"},  32'(bus.wt_valid), 0);
        check({tag, "_flags"},  32'({bus.wt_first, bus.wt_last, bus.wt_layer_last}), 0);
        check({tag, "_data"},   32'(bus.wt_data), 0);
        check({tag, "_bias"},   32'(bus.wt_bias), 0);
        check({tag, "_w_addr"}, 32'(bus.w_addr), 0);
        check({tag, "_b_addr"}, 32'(bus.b_addr), 0);
    endtask

    // Expected stream straight from the layer definition.
    task automatic build_model(input int wb, input int bb, input int oc, input int ic, input int kn);
        exp_q.delete();
        exp_addr.delete();
        for (int o = 0; o < oc; o++)
            for (int i = 0; i < ic; i++)
                for (int k = 0; k < kn; k++) begin
                    exp_t e;
                    int a;
                    a    = (wb + (o * ic + i) * kn + k) % (2**WA);
                    e.w  = wrom[a];
                    e.b  = brom[(bb + o) % (2**BA)];
                    e.f  = (i == 0) && (k == 0);
                    e.l  = (i == ic - 1) && (k == kn - 1);
                    e.ll = e.l && (o == oc - 1);
                    exp_q.push_back(e);
                    exp_addr.push_back(a);
                end
    endtask

    task automatic drive_start(input int wb, input int bb, input int oc, input int ic, input int kn);
        bus.start  = 1'b1;
        bus.w_base = WA'(wb);
        bus.b_base = BA'(bb);
        bus.out_ch = CW'(oc);
        bus.in_ch  = CW'(ic);
        bus.kernel = KW'(kn);
    endtask

    task automatic scramble_desc();
        bus.w_base = WA'($urandom);
        bus.b_base = BA'($urandom);
        bus.out_ch = CW'($urandom_range(1, 31));
        bus.in_ch  = CW'($urandom_range(1, 31));
        bus.kernel = KW'($urandom_range(1, 3));
    endtask

    // mode 0: ready held high, 1: fixed 8-cycle pattern, 2: random ready.
    // Entered and left on a negedge.
    task automatic run_layer(input int wb, input int bb, input int oc, input int ic, input int kn,
                             input int mode, input bit poke_busy, input bit poke_done);
        int  cyc, beats, last_acc, done_cyc;
        bit  zero, prev_hold;
        logic [27:0] snap, prev_snap;
        logic [WA-1:0] addr0;
        int  seen[$];
        exp_t e;

        zero = (oc == 0) || (ic == 0) || (kn == 0);
        build_model(wb, bb, oc, ic, kn);
        addr0 = bus.w_addr;
        bus.wt_ready = 1'b1;
        drive_start(wb, bb, oc, ic, kn);
        @(negedge clk);
        bus.start = 1'b0;
        scramble_desc();
        cyc = 1; beats = 0; last_acc = -1; done_cyc = -1; prev_hold = 0; prev_snap = '0;
        while (cyc < 20000) begin
            snap = {bus.wt_valid, bus.wt_data, bus.wt_bias, bus.wt_first, bus.wt_last,
                    bus.wt_layer_last};
            if (!zero && (seen.size() == 0 || seen[$] != int'(bus.w_addr)))
                seen.push_back(int'(bus.w_addr));
            if (cyc == 1) check("busy_after_start", 32'(bus.busy), 1);
            if (prev_hold) check("head_stable", 32'(snap), 32'(prev_snap));
            if (mode == 0 && !zero && cyc <= 3)
                check("first_latency", 32'(bus.wt_valid), 32'(cyc == 3));
            bus.start = 1'b0;
            if (poke_busy && cyc == 5) begin
                bus.start = 1'b1;
                scramble_desc();
            end
            if (bus.done) begin
                done_cyc = cyc;
                check("busy_in_done", 32'(bus.busy), 1);
                if (poke_done) begin
                    bus.start = 1'b1;
                    scramble_desc();
                end
            end
            case (mode)
                0:       bus.wt_ready = 1'b1;
                1:       bus.wt_ready = pat[(cyc - 1) % 8];
                default: bus.wt_ready = ($urandom % 4) != 0;
            endcase
            if (bus.wt_valid && bus.wt_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(bus.wt_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wt_data", 32'(bus.wt_data), 32'(e.w));
                    check("wt_bias", 32'(bus.wt_bias), 32'(e.b));
                    check("wt_flags", 32'({bus.wt_first, bus.wt_last, bus.wt_layer_last}),
                          32'({e.f, e.l, e.ll}));
                    if (mode == 0) check("beat_cycle", 32'(cyc), 32'(3 + beats));
                end
                last_acc = cyc;
                beats++;
            end
            prev_hold = bus.wt_valid && !bus.wt_ready;
            prev_snap = snap;
            if (done_cyc >= 0) break;
            @(negedge clk);
            cyc++;
        end
        check("done_timeout", 32'(done_cyc >= 0), 1);
        check("beats_missing", 32'(exp_q.size()), 0);
        if (zero) begin
            check("zero_done_cycle", 32'(done_cyc), 1);
            check("zero_beats", 32'(beats), 0);
            check("zero_addr_hold", 32'(bus.w_addr), 32'(addr0));
        end else begin
            check("done_after_last", 32'(done_cyc), 32'(last_acc + 1));
            check("addr_count", 32'(seen.size()), 32'(exp_addr.size()));
            for (int i = 0; i < seen.size() && i < exp_addr.size(); i++)
                check("w_addr_seq", 32'(seen[i]), 32'(exp_addr[i]));
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_drop", 32'(bus.busy), 0);
        check("done_pulse", 32'(bus.done), 0);
    endtask

    task automatic mid_reset();
        int   cyc, beats;
        exp_t e;
        build_model(0, 0, 4, 2, 3);
        bus.wt_ready = 1'b1;
        drive_start(0, 0, 4, 2, 3);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1; beats = 0;
        while (beats < 10 && cyc < 200) begin
            if (bus.wt_valid) begin
                e = exp_q.pop_front();
                check("rst_run_data", 32'(bus.wt_data), 32'(e.w));
                beats++;
            end
            @(negedge clk);
            cyc++;
        end
        check("pre_rst_valid", 32'(bus.wt_valid), 1);
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_rst");
        @(negedge clk);
        check("mid_rst_no_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 0);
        check("post_rst_done", 32'(bus.done), 0);
        check("post_rst_valid", 32'(bus.wt_valid), 0);
    endtask

    initial begin
        for (int i = 0; i < 2**WA; i++) wrom[i] = WW'($urandom);
        for (int i = 0; i < 2**BA; i++) brom[i] = BW'($urandom);
        wrom[0] = 8'h20;
        brom[0] = 16'h0010;
        wrom[216] = 8'h50; wrom[217] = 8'h40; wrom[218] = 8'h48; wrom[219] = 8'h38;
        wrom[220] = 8'h58; wrom[221] = 8'h30; wrom[222] = 8'h44; wrom[223] = 8'h3C;
        brom[16] = 16'h0000;
        brom[17] = 16'h0000;
        bus.start = 1'b0;
        bus.w_base = '0; bus.b_base = '0; bus.out_ch = '0; bus.in_ch = '0; bus.kernel = '0;
        bus.wt_ready = 1'b1;

        #1 rst_n = 1'b0;
        #1 check_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_layer(0, 0, 4, 2, 3, 0, 0, 0);       // encoder conv1
        run_layer(216, 16, 2, 4, 1, 0, 0, 0);    // output conv
        run_layer(0, 0, 4, 2, 3, 1, 1, 1);       // backpressure + ignored starts
        run_layer(2046, 5, 1, 1, 3, 0, 0, 0);    // address wrap
        run_layer(100, 3, 2, 2, 0, 0, 0, 0);     // zero kernel
        mid_reset();
        run_layer(0, 0, 4, 2, 3, 0, 0, 0);
        repeat (6)
            run_layer(int'($urandom_range(0, 2047)), int'($urandom_range(0, 63)),
                      int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
                      int'($urandom_range(1, 3)), 2, 1, 0);
        run_layer(1500, 60, 31, 31, 3, 2, 0, 1); // largest layer, wraps weight ROM

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
